regfile_port_arbiter: RTL and testbench
=======================================

# regfile_port_arbiter

Controller that owns the ports of the 32×32 integer register file in the single-cycle RISC-V core. After reset it sequences a clear of every architectural register. It then shares the file's write port and read port 1 between the core writeback path and a debug access port, using a valid/ready handshake and bounded-wait starvation protection. It sits between the core datapath and the register file; all register-file port signals go through it.

## Interface
Parameters:
- N, 6, register address width (matches register file)
- M, 32, data width
- L, 32, number of registers
- MAX_WAIT, 4, max cycles a pending debug write yields to core writeback before stealing the port

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- core_a1, core_a2  in  N  core read addresses
- wb_we  in  1  core writeback enable
- wb_addr  in  N  core writeback address
- wb_data  in  M  core writeback data
- core_rd1  out  M  read data 1 to core (= rf_rd1)
- core_stall  out  1  core must hold its current instruction; its writeback this cycle is discarded
- dbg_valid  in  1  debug request valid
- dbg_wr  in  1  1 = write, 0 = read
- dbg_addr  in  N  debug register address
- dbg_wdata  in  M  debug write data
- dbg_ready  out  1  request accepted this cycle (valid && ready)
- dbg_rvalid  out  1  one-cycle pulse, dbg_rdata valid
- dbg_rdata  out  M  registered debug read data
- rf_we3, rf_a1, rf_a2, rf_a3, rf_wd3  out  to register file
- rf_rd1  in  M  register file read data 1

## Operation
- States: CLEAR, RUN. Reset enters CLEAR (or RUN without REGFILE_CLEAR_EN). No other states exist.
- CLEAR: rf_we3=1, rf_a3=clr_ptr, rf_wd3=0, core_stall=1, dbg_ready=0. clr_ptr starts at 1 and increments each cycle. On the cycle clr_ptr==L-1 the write still happens, then the block moves to RUN. The clear takes L-1 cycles. Register 0 is never written.
- RUN, default passthrough: rf_a1=core_a1, rf_a2=core_a2, rf_we3=wb_we, rf_a3=wb_addr, rf_wd3=wb_data, core_stall=0.
- Debug write accepted (dbg_ready=1) when dbg_valid && dbg_wr && (!wb_we || wait_cnt==MAX_WAIT).
  - If wb_we=1 at accept, core_stall=1 and the core write is suppressed.
  - rf_we3=(dbg_addr!=0), rf_a3=dbg_addr, rf_wd3=dbg_wdata.
  - A write to x0 completes the handshake with no write.
- Debug read accepted whenever dbg_valid && !dbg_wr.
  - The accept cycle forces core_stall=1, rf_we3=0 and rf_a1=dbg_addr.
  - rf_rd1 is captured into dbg_rdata at that edge; dbg_rvalid pulses the next cycle.
  - Address 0 returns 0.
- wait_cnt (saturating, width clog2(MAX_WAIT+1)):
  - Increments each RUN cycle with dbg_valid && dbg_wr && !dbg_ready.
  - Clears on accept or when dbg_valid drops.
  - Held at 0 in CLEAR.
- Only one debug request is handled per cycle. Back-to-back accepts are allowed.

## Timing
- Reset values: state=CLEAR, clr_ptr=1, wait_cnt=0, dbg_rdata=0, dbg_rvalid=0. Combinational outputs follow state: core_stall=1, dbg_ready=0 in CLEAR.
- Asserting rst_n low mid-CLEAR or mid-RUN restarts the clear from address 1. A pending debug request is dropped.
- Debug write latency: written at the accept edge. Wait is at most MAX_WAIT cycles of core writes, then a 1-cycle stall.
- Debug read latency: dbg_rvalid 1 cycle after accept. Each read costs exactly one core stall cycle.
- dbg_ready is combinational from dbg_valid, dbg_wr, wb_we and state. The debug side must not make dbg_valid depend on dbg_ready.
- A core write and a debug write to the same address in a non-stealing cycle cannot occur, because the debug write is only accepted when wb_we=0.

## Configuration
- REGFILE_CLEAR_EN defined:
  - CLEAR state is present.
  - Registers x1..x(L-1) read 0 after L-1 cycles.
  - Core is stalled throughout.
- REGFILE_CLEAR_EN undefined:
  - CLEAR logic and clr_ptr are removed.
  - Reset goes straight to RUN, core_stall=0 from the first cycle, and register contents are undefined.

## Test plan
- Reset with REGFILE_CLEAR_EN: core_stall=1 for exactly 31 cycles, and rf writes 0 to addresses 1..31 in order. Then passthrough, with reads of x5 and x31 returning 0.
- RUN, wb_we=0, debug write x7=0xDEADBEEF: dbg_ready=1 the same cycle, core_stall=0. A later core read of x7 returns 0xDEADBEEF.
- wb_we held 1 continuously, debug write x3=0x12345678:
  - dbg_ready stays low for 4 cycles, then on the 5th cycle dbg_ready=1 and core_stall=1.
  - x3 is written; the core's write that cycle is absent.
  - wait_cnt returns to 0.
- Debug read of x7 after the write test: one core_stall cycle, rf_a1=7. dbg_rvalid pulses the next cycle with dbg_rdata=0xDEADBEEF. Debug read of x0 returns 0.
- Debug write x0=0xFFFFFFFF: handshake completes, rf_we3=0, and x0 still reads 0.
- rst_n pulsed low at clear address 15: restart from address 1 with no early exit to RUN. Pending dbg_valid is not acknowledged until RUN.

Source files
------------

// File: rtl/regfile_port_arbiter.sv
// rtl/regfile_port_arbiter.sv - register-file port owner: post-reset clear plus core/debug port sharing
//
// Optional feature macro: REGFILE_CLEAR_EN
//   defined   : reset enters CLEAR, zeroes x1..x(L-1) over L-1 cycles with the core stalled.
//   undefined : reset goes straight to RUN and register contents are left as found.
//
// Ports
//   clk, rst_n                      core clock, asynchronous active-low reset
//   core_a1, core_a2                core read addresses
//   wb_we, wb_addr, wb_data         core writeback request
//   core_rd1                        read data 1 back to the core (straight from rf_rd1)
//   core_stall                      core holds its instruction; its writeback this cycle is dropped
//   dbg_valid, dbg_wr, dbg_addr,
//   dbg_wdata                       debug request (dbg_wr=1 write, 0 read)
//   dbg_ready                       debug request accepted this cycle
//   dbg_rvalid, dbg_rdata           registered debug read response, one-cycle pulse
//   rf_we3, rf_a1, rf_a2, rf_a3,
//   rf_wd3, rf_rd1                  register-file ports
module regfile_port_arbiter #(
    parameter int N        = 6,
    parameter int M        = 32,
    parameter int L        = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] core_a1,
    input  logic [N-1:0] core_a2,
    input  logic         wb_we,
    input  logic [N-1:0] wb_addr,
    input  logic [M-1:0] wb_data,
    output logic [M-1:0] core_rd1,
    output logic         core_stall,
    input  logic         dbg_valid,
    input  logic         dbg_wr,
    input  logic [N-1:0] dbg_addr,
    input  logic [M-1:0] dbg_wdata,
    output logic         dbg_ready,
    output logic         dbg_rvalid,
    output logic [M-1:0] dbg_rdata,
    output logic         rf_we3,
    output logic [N-1:0] rf_a1,
    output logic [N-1:0] rf_a2,
    output logic [N-1:0] rf_a3,
    output logic [M-1:0] rf_wd3,
    input  logic [M-1:0] rf_rd1
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [WW-1:0] wait_cnt;
    logic          rd_accept;

    assign core_rd1 = rf_rd1;

`ifdef REGFILE_CLEAR_EN
    localparam logic [N-1:0] CLR_LAST = N'(L - 1);

    logic [N-1:0] clr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_CLEAR;
            clr_ptr <= N'(1);
        end else begin
            state <= state_next;
            if (state == ST_CLEAR) begin
                clr_ptr <= clr_ptr + N'(1);
            end
        end
    end
`else
    localparam int unused_l = L;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end
`endif

    always_comb begin
        state_next = state;
        rf_a1      = core_a1;
        rf_a2      = core_a2;
        rf_we3     = wb_we;
        rf_a3      = wb_addr;
        rf_wd3     = wb_data;
        core_stall = 1'b0;
        dbg_ready  = 1'b0;
        rd_accept  = 1'b0;

        if (state == ST_CLEAR) begin
`ifdef REGFILE_CLEAR_EN
            rf_we3     = 1'b1;
            rf_a3      = clr_ptr;
            rf_wd3     = '0;
            core_stall = 1'b1;
            if (clr_ptr == CLR_LAST) begin
                state_next = ST_RUN;
            end
`endif
        end else if (dbg_valid && !dbg_wr) begin
            // Reads borrow read port 1 for one cycle; the stall keeps the core
            // from committing anything computed from the wrong read data.
            dbg_ready  = 1'b1;
            rd_accept  = 1'b1;
            core_stall = 1'b1;
            rf_we3     = 1'b0;
            rf_a1      = dbg_addr;
        end else if (dbg_valid && dbg_wr && (!wb_we || wait_cnt == WAIT_MAX)) begin
            // Stealing from an active writeback stalls the core so it replays
            // the discarded write next cycle.
            dbg_ready  = 1'b1;
            core_stall = wb_we;
            rf_we3     = (dbg_addr != '0);
            rf_a3      = dbg_addr;
            rf_wd3     = dbg_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state != ST_RUN || !dbg_valid || dbg_ready) begin
            wait_cnt <= '0;
        end else if (dbg_wr && wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + WW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_rdata  <= '0;
            dbg_rvalid <= 1'b0;
        end else begin
            dbg_rvalid <= rd_accept;
            if (rd_accept) begin
                dbg_rdata <= (dbg_addr == '0) ? '0 : rf_rd1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb/tb_regfile_port_arbiter.sv - directed self-checking bench for regfile_port_arbiter
module tb_regfile_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic [5:0]  core_a1;
    logic [5:0]  core_a2;
    logic        wb_we;
    logic [5:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] core_rd1;
    logic        core_stall;
    logic        dbg_valid;
    logic        dbg_wr;
    logic [5:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ready;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        rf_we3;
    logic [5:0]  rf_a1;
    logic [5:0]  rf_a2;
    logic [5:0]  rf_a3;
    logic [31:0] rf_wd3;
    logic [31:0] rf_rd1;

    int n_checks;
    int n_fail;

    logic [31:0] mem [0:63];

    regfile_port_arbiter #(.N(6), .M(32), .L(32), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_a1(core_a1), .core_a2(core_a2),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .core_rd1(core_rd1), .core_stall(core_stall),
        .dbg_valid(dbg_valid), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ready(dbg_ready), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .rf_we3(rf_we3), .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_a3(rf_a3),
        .rf_wd3(rf_wd3), .rf_rd1(rf_rd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: junk contents at reset except x0, plain memory otherwise.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) mem[i] <= (i == 0) ? 32'h0 : 32'hA5A5A5A5;
        end else if (rf_we3) begin
            mem[rf_a3] <= rf_wd3;
        end
    end
    assign rf_rd1 = mem[rf_a1];

    task automatic test_reset();
        @(negedge clk); #1;
        n_checks++; if (dbg_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %0b want 0", dbg_rvalid); end
        n_checks++; if (dbg_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", dbg_rdata); end
`ifdef REGFILE_CLEAR_EN
        n_checks++; if (core_stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall: got %0b want 1", core_stall); end
        n_checks++; if (dbg_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0b want 0", dbg_ready); end
`endif
        @(negedge clk); rst_n = 1'b1; #1;
`ifdef REGFILE_CLEAR_EN
        for (int i = 1; i < 32; i++) begin
            n_checks++; if (core_stall !== 1'b1 || rf_we3 !== 1'b1 || rf_a3 !== 6'(i) || rf_wd3 !== 32'h0) begin
                n_fail++; $display("FAIL clear_seq[%0d]: got stall=%0b we=%0b a3=%0d wd=%h want 1 1 %0d 0", i, core_stall, rf_we3, rf_a3, rf_wd3, i);
            end
            @(negedge clk); #1;
        end
        n_checks++; if (core_stall !== 1'b0) begin n_fail++; $display("FAIL clear_end_stall: got %0b want 0", core_stall); end
        core_a1 = 6'd5; #1;
        n_checks++; if (core_rd1 !== 32'h0) begin n_fail++; $display("FAIL clear_x5: got %h want 0", core_rd1); end
        core_a1 = 6'd31; #1;
        n_checks++; if (core_rd1 !== 32'h0) begin n_fail++; $display("FAIL clear_x31: got %h want 0", core_rd1); end
`else
        n_checks++; if (core_stall !== 1'b0) begin n_fail++; $display("FAIL run_first_stall: got %0b want 0", core_stall); end
`endif
        n_checks++; if (rf_we3 !== 1'b0 || rf_a1 !== core_a1) begin n_fail++; $display("FAIL passthrough: got we=%0b a1=%0d want 0 %0d", rf_we3, rf_a1, core_a1); end
    endtask

    task automatic test_debug_write();
        @(negedge clk);
        wb_we = 1'b0; dbg_valid = 1'b1; dbg_wr = 1'b1; dbg_addr = 6'd7; dbg_wdata = 32'hDEADBEEF; #1;
        n_checks++; if (dbg_ready !== 1'b1 || core_stall !== 1'b0) begin n_fail++; $display("FAIL wr_accept: got ready=%0b stall=%0b want 1 0", dbg_ready, core_stall); end
        n_checks++; if (rf_we3 !== 1'b1 || rf_a3 !== 6'd7 || rf_wd3 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_port: got we=%0b a3=%0d wd=%h want 1 7 deadbeef", rf_we3, rf_a3, rf_wd3); end
        @(negedge clk); dbg_valid = 1'b0; core_a1 = 6'd7; #1;
        n_checks++; if (core_rd1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_readback: got %h want deadbeef", core_rd1); end
    endtask

    task automatic test_starvation();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            wb_we = 1'b1; wb_addr = 6'd10; wb_data = 32'h1000 + 32'(k);
            dbg_valid = 1'b1; dbg_wr = 1'b1; dbg_addr = 6'd3; dbg_wdata = 32'h12345678; #1;
            if (k < 4) begin
                n_checks++; if (dbg_ready !== 1'b0 || core_stall !== 1'b0 || rf_a3 !== 6'd10 || rf_wd3 !== 32'h1000 + 32'(k)) begin
                    n_fail++; $display("FAIL starve_wait[%0d]: got ready=%0b stall=%0b a3=%0d wd=%h want 0 0 10 %h", k, dbg_ready, core_stall, rf_a3, rf_wd3, 32'h1000 + 32'(k));
                end
            end else begin
                n_checks++; if (dbg_ready !== 1'b1 || core_stall !== 1'b1 || rf_we3 !== 1'b1 || rf_a3 !== 6'd3 || rf_wd3 !== 32'h12345678) begin
                    n_fail++; $display("FAIL starve_steal: got ready=%0b stall=%0b we=%0b a3=%0d wd=%h want 1 1 1 3 12345678", dbg_ready, core_stall, rf_we3, rf_a3, rf_wd3);
                end
            end
        end
        @(negedge clk); dbg_addr = 6'd4; dbg_wdata = 32'h44; wb_data = 32'h1005; #1;
        n_checks++; if (dbg_ready !== 1'b0) begin n_fail++; $display("FAIL starve_wait_cleared: got ready=%0b want 0", dbg_ready); end
        n_checks++; if (mem[3] !== 32'h12345678) begin n_fail++; $display("FAIL starve_x3: got %h want 12345678", mem[3]); end
        n_checks++; if (mem[10] !== 32'h1003) begin n_fail++; $display("FAIL starve_core_suppressed: got %h want 00001003", mem[10]); end
        @(negedge clk); dbg_valid = 1'b0; wb_we = 1'b0; #1;
        n_checks++; if (mem[10] !== 32'h1005) begin n_fail++; $display("FAIL starve_core_resume: got %h want 00001005", mem[10]); end
    endtask

    task automatic test_debug_read();
        @(negedge clk);
        wb_we = 1'b1; wb_addr = 6'd11; wb_data = 32'hBAD; core_a1 = 6'd2;
        dbg_valid = 1'b1; dbg_wr = 1'b0; dbg_addr = 6'd7; #1;
        n_checks++; if (dbg_ready !== 1'b1 || core_stall !== 1'b1 || rf_we3 !== 1'b0 || rf_a1 !== 6'd7) begin
            n_fail++; $display("FAIL rd_accept: got ready=%0b stall=%0b we=%0b a1=%0d want 1 1 0 7", dbg_ready, core_stall, rf_we3, rf_a1);
        end
        @(negedge clk); dbg_valid = 1'b0; wb_we = 1'b0; #1;
        n_checks++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'hDEADBEEF || core_stall !== 1'b0) begin
            n_fail++; $display("FAIL rd_response: got rvalid=%0b rdata=%h stall=%0b want 1 deadbeef 0", dbg_rvalid, dbg_rdata, core_stall);
        end
        n_checks++; if (mem[11] === 32'hBAD) begin n_fail++; $display("FAIL rd_core_write_blocked: got %h want not 00000bad", mem[11]); end
        @(negedge clk); #1;
        n_checks++; if (dbg_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_pulse_width: got %0b want 0", dbg_rvalid); end
    endtask

    task automatic test_x0();
        @(negedge clk);
        wb_we = 1'b0; dbg_valid = 1'b1; dbg_wr = 1'b1; dbg_addr = 6'd0; dbg_wdata = 32'hFFFFFFFF; #1;
        n_checks++; if (dbg_ready !== 1'b1 || rf_we3 !== 1'b0) begin n_fail++; $display("FAIL x0_write: got ready=%0b we=%0b want 1 0", dbg_ready, rf_we3); end
        @(negedge clk); dbg_valid = 1'b0; core_a1 = 6'd0; #1;
        n_checks++; if (core_rd1 !== 32'h0 || mem[0] !== 32'h0) begin n_fail++; $display("FAIL x0_still_zero: got %h want 0", mem[0]); end
        @(negedge clk); dbg_valid = 1'b1; dbg_wr = 1'b0; dbg_addr = 6'd0; #1;
        n_checks++; if (dbg_ready !== 1'b1) begin n_fail++; $display("FAIL x0_read_accept: got %0b want 1", dbg_ready); end
        @(negedge clk); dbg_valid = 1'b0; #1;
        n_checks++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'h0) begin n_fail++; $display("FAIL x0_read: got rvalid=%0b rdata=%h want 1 0", dbg_rvalid, dbg_rdata); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        wb_we = 1'b0; dbg_valid = 1'b1; dbg_wr = 1'b1; dbg_addr = 6'd12; dbg_wdata = 32'hCAFEF00D; #1;
        n_checks++; if (dbg_ready !== 1'b1 || rf_a3 !== 6'd12) begin n_fail++; $display("FAIL b2b_write: got ready=%0b a3=%0d want 1 12", dbg_ready, rf_a3); end
        @(negedge clk); dbg_wr = 1'b0; #1;
        n_checks++; if (dbg_ready !== 1'b1 || rf_a1 !== 6'd12 || core_stall !== 1'b1) begin n_fail++; $display("FAIL b2b_read: got ready=%0b a1=%0d stall=%0b want 1 12 1", dbg_ready, rf_a1, core_stall); end
        @(negedge clk); dbg_valid = 1'b0; #1;
        n_checks++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL b2b_rdata: got rvalid=%0b rdata=%h want 1 cafef00d", dbg_rvalid, dbg_rdata); end
    endtask

    task automatic test_reset_restart();
        @(negedge clk); dbg_valid = 1'b1; dbg_wr = 1'b0; dbg_addr = 6'd12; #1;
        @(negedge clk); dbg_valid = 1'b0; rst_n = 1'b0; #1;
        n_checks++; if (dbg_rvalid !== 1'b0 || dbg_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_regs: got rvalid=%0b rdata=%h want 0 0", dbg_rvalid, dbg_rdata); end
        @(negedge clk); rst_n = 1'b1; #1;
`ifdef REGFILE_CLEAR_EN
        for (int k = 1; k < 15; k++) begin
            @(negedge clk); #1;
        end
        n_checks++; if (rf_a3 !== 6'd15) begin n_fail++; $display("FAIL rst_reach15: got %0d want 15", rf_a3); end
        dbg_valid = 1'b1; dbg_wr = 1'b1; dbg_addr = 6'd9; dbg_wdata = 32'h99; rst_n = 1'b0; #1;
        n_checks++; if (rf_a3 !== 6'd1 || core_stall !== 1'b1 || dbg_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_clear: got a3=%0d stall=%0b ready=%0b want 1 1 0", rf_a3, core_stall, dbg_ready);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        for (int i = 1; i < 32; i++) begin
            n_checks++; if (rf_a3 !== 6'(i) || core_stall !== 1'b1 || dbg_ready !== 1'b0) begin
                n_fail++; $display("FAIL restart_seq[%0d]: got a3=%0d stall=%0b ready=%0b want %0d 1 0", i, rf_a3, core_stall, dbg_ready, i);
            end
            @(negedge clk); #1;
        end
`else
        dbg_valid = 1'b1; dbg_wr = 1'b1; dbg_addr = 6'd9; dbg_wdata = 32'h99; #1;
`endif
        n_checks++; if (dbg_ready !== 1'b1 || rf_a3 !== 6'd9 || core_stall !== 1'b0) begin
            n_fail++; $display("FAIL rst_run_accept: got ready=%0b a3=%0d stall=%0b want 1 9 0", dbg_ready, rf_a3, core_stall);
        end
        @(negedge clk); dbg_valid = 1'b0; #1;
        n_checks++; if (mem[9] !== 32'h99) begin n_fail++; $display("FAIL rst_run_write: got %h want 00000099", mem[9]); end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        core_a1   = '0;
        core_a2   = 6'd1;
        wb_we     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        dbg_valid = 1'b0;
        dbg_wr    = 1'b0;
        dbg_addr  = '0;
        dbg_wdata = '0;
        test_reset();
        test_debug_write();
        test_starvation();
        test_debug_read();
        test_x0();
        test_back_to_back();
        test_reset_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
